// File: rtl/p_d_cache_wb_buffer_if.sv
// Bus bundle between the D-cache line port, the write-back buffer and the
// downstream memory arbiter. The buffer takes the slave view; the driver side takes master.
interface p_d_cache_wb_buffer_if;
    logic [31:0]  cache_address;
    logic [255:0] cache_wdata;
    logic         cache_read;
    logic         cache_write;
    logic         cache_resp;
    logic [255:0] cache_rdata;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_read;
    logic         pmem_write;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;
    logic         buf_empty;

    modport slave (
        input  cache_address, cache_wdata, cache_read, cache_write, pmem_resp, pmem_rdata,
        output cache_resp, cache_rdata, pmem_address, pmem_wdata, pmem_read, pmem_write,
        buf_empty
    );

    modport master (
        output cache_address, cache_wdata, cache_read, cache_write, pmem_resp, pmem_rdata,
        input  cache_resp, cache_rdata, pmem_address, pmem_wdata, pmem_read, pmem_write,
        buf_empty
    );
endinterface

// File: rtl/p_d_cache_wb_buffer.sv
// Write-back buffer: absorbs dirty-line evictions in a small FIFO, serves read
// hits from it, coalesces rewrites and drains lines to memory when the port is idle.
module p_d_cache_wb_buffer #(
    parameter int DEPTH    = 4,
    parameter int s_offset = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    p_d_cache_wb_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TAG_W = 32 - s_offset;

    typedef enum logic [1:0] {IDLE, READ_MEM, WRITE_MEM} state_t;

    logic [TAG_W-1:0] r_tag  [DEPTH];
    logic [255:0]     r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    state_t           r_state;

    logic             r_resp;
    logic [255:0]     r_rdata;
    logic             r_pmem_read;
    logic             r_pmem_write;
    logic [31:0]      r_pmem_addr;
    logic [255:0]     r_pmem_wdata;

    logic [TAG_W-1:0] w_req_tag;
    logic             w_unused_low;
    logic             w_full;
    logic             w_head_lock;
    logic             w_rd_hit;
    logic             w_wr_hit;
    logic [PTR_W-1:0] w_rd_idx;
    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_idx;
    logic             w_accept_rd;
    logic             w_coalesce;
    logic             w_enq;
    logic             w_deq;
    logic             w_miss;

    assign w_req_tag    = bus.cache_address[31:s_offset];
    assign w_unused_low = ^bus.cache_address[s_offset-1:0];
    assign w_full       = (r_count == (PTR_W+1)'(DEPTH));

    // The head is frozen once a drain is running or about to launch at this edge,
    // otherwise a coalesce could race the capture of pmem_wdata.
    assign w_head_lock  = (r_state == WRITE_MEM) || (r_state == IDLE && r_count != '0);

    // Scan oldest to newest so the last match wins (newest copy of a line).
    always_comb begin
        w_rd_hit = 1'b0;
        w_wr_hit = 1'b0;
        w_rd_idx = r_head;
        w_wr_idx = r_head;
        w_idx    = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if (r_valid[w_idx] && r_tag[w_idx] == w_req_tag) begin
                w_rd_hit = 1'b1;
                w_rd_idx = w_idx;
                if (!(w_head_lock && w_idx == r_head)) begin
                    w_wr_hit = 1'b1;
                    w_wr_idx = w_idx;
                end
            end
        end
    end

    // Requests are held through their resp cycle, so they are ignored while r_resp is high.
    assign w_accept_rd = !r_resp && bus.cache_read && w_rd_hit;
    assign w_miss      = !r_resp && bus.cache_read && !w_rd_hit;
    assign w_coalesce  = !r_resp && bus.cache_write && w_wr_hit;
    assign w_enq       = !r_resp && bus.cache_write && !w_wr_hit && !w_full;
    assign w_deq       = (r_state == WRITE_MEM) && bus.pmem_resp;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_tag[r_tail]  <= w_req_tag;
            r_data[r_tail] <= bus.cache_wdata;
        end else if (w_coalesce) begin
            r_data[w_wr_idx] <= bus.cache_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid      <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_state      <= IDLE;
            r_resp       <= 1'b0;
            r_rdata      <= '0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_pmem_addr  <= '0;
            r_pmem_wdata <= '0;
        end else begin
            r_resp <= w_accept_rd || w_enq || w_coalesce;
            if (w_accept_rd) begin
                r_rdata <= r_data[w_rd_idx];
            end
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_deq) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase

            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_state     <= READ_MEM;
                        r_pmem_read <= 1'b1;
                        r_pmem_addr <= {bus.cache_address[31:s_offset], {s_offset{1'b0}}};
                    end else if (r_count != '0) begin
                        r_state      <= WRITE_MEM;
                        r_pmem_write <= 1'b1;
                        r_pmem_addr  <= {r_tag[r_head], {s_offset{1'b0}}};
                        r_pmem_wdata <= r_data[r_head];
                    end
                end
                READ_MEM: begin
                    if (bus.pmem_resp) begin
                        r_state     <= IDLE;
                        r_pmem_read <= 1'b0;
                        r_rdata     <= bus.pmem_rdata;
                        r_resp      <= 1'b1;
                    end
                end
                WRITE_MEM: begin
                    if (bus.pmem_resp) begin
                        r_state      <= IDLE;
                        r_pmem_write <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cache_resp   = r_resp;
    assign bus.cache_rdata  = r_rdata;
    assign bus.pmem_read    = r_pmem_read;
    assign bus.pmem_write   = r_pmem_write;
    assign bus.pmem_address = r_pmem_addr;
    assign bus.pmem_wdata   = r_pmem_wdata;
    assign bus.buf_empty    = (r_count == '0) && (r_state == IDLE) && !r_resp;
endmodule

// File: tb/tb_p_d_cache_wb_buffer.sv
// Scoreboard bench for p_d_cache_wb_buffer: directed cache traffic against a
// 3-cycle memory model that can withhold responses.
module tb_p_d_cache_wb_buffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    p_d_cache_wb_buffer_if bus();
    p_d_cache_wb_buffer #(.DEPTH(4), .s_offset(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {bit is_read; logic [255:0] data;} cexp_t;
    typedef struct {bit is_write; logic [31:0] addr; logic [255:0] data;} pexp_t;

    cexp_t cq[$];
    pexp_t pq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_presp_cyc = 0;
    int    last_resp_cyc = 0;
    bit    mem_hold = 1'b0;
    bit    mem_flush = 1'b0;
    int    mem_grant = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] pat(input logic [31:0] s);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = s ^ (32'h1111_1111 * i);
        return r;
    endfunction

    function automatic logic [255:0] memdat(input logic [31:0] a);
        return pat(~a);
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic push_pm(input bit is_wr, input logic [31:0] addr, input logic [255:0] data);
        pexp_t p;
        p.is_write = is_wr;
        p.addr     = addr;
        p.data     = data;
        pq.push_back(p);
    endtask

    // Cache monitor: every resp must be expected; read resps carry data to compare.
    cexp_t ce;
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.cache_resp === 1'b1) begin
            if (cq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cache_resp: got resp at cycle %0d expected none", cyc);
            end else begin
                ce = cq.pop_front();
                if (ce.is_read) chk("cache_rdata", bus.cache_rdata, ce.data);
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) assert (!(bus.cache_read && bus.cache_write));
    end

    // Memory model: checks each request against the expected drain/read order.
    pexp_t       pe;
    logic        m_wr;
    logic [31:0] m_addr;
    logic [255:0] m_data;
    logic        m_stable;
    int          m_wait;
    initial begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && (bus.pmem_read === 1'b1 || bus.pmem_write === 1'b1)) begin
                m_wr     = bus.pmem_write;
                m_addr   = bus.pmem_address;
                m_data   = bus.pmem_wdata;
                m_stable = 1'b1;
                if (pq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pmem_req: got write=%b addr %h expected none", m_wr, m_addr);
                end else begin
                    pe = pq.pop_front();
                    chk_bit("pmem_is_write", m_wr, pe.is_write);
                    chk("pmem_address", 256'(m_addr), 256'(pe.addr));
                    if (pe.is_write) chk("pmem_wdata", m_data, pe.data);
                end
                m_wait = 0;
                while (mem_hold && mem_grant == 0 && !mem_flush && m_wait < 5000) begin
                    @(negedge clk);
                    m_wait++;
                    if (rst === 1'b1 && !mem_flush &&
                        (bus.pmem_write !== m_wr || bus.pmem_read !== !m_wr || bus.pmem_address !== m_addr))
                        m_stable = 1'b0;
                end
                if (m_wait >= 5000) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_hold_timeout: got %0d cycles expected release", m_wait);
                end
                if (mem_flush) continue;
                if (mem_hold && mem_grant > 0) mem_grant--;
                repeat (2) @(posedge clk);
                @(posedge clk);
                #1;
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = m_wr ? '0 : memdat(m_addr);
                last_presp_cyc = cyc;
                @(posedge clk);
                #1;
                bus.pmem_resp  = 1'b0;
                chk_bit("pmem_req_stable", m_stable, 1'b1);
            end
        end
    end

    // Drives one held request; n counts sampling edges until resp is visible.
    task automatic cache_op(input bit is_rd, input logic [31:0] addr, input logic [255:0] wd,
                            input logic [255:0] exp_rd, input int exp_lat, input string name);
        cexp_t e;
        int n;
        e.is_read = is_rd;
        e.data    = exp_rd;
        cq.push_back(e);
        @(posedge clk);
        #1;
        bus.cache_address = addr;
        bus.cache_wdata   = wd;
        bus.cache_read    = is_rd;
        bus.cache_write   = !is_rd;
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.cache_resp === 1'b1) break;
        end
        if (bus.cache_resp !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no cache_resp expected one", name);
            if (cq.size() > 0) void'(cq.pop_back());
        end else begin
            last_resp_cyc = cyc;
            if (exp_lat >= 0) chk_int({name, "_latency"}, n, exp_lat);
        end
        @(posedge clk);
        #1;
        bus.cache_read  = 1'b0;
        bus.cache_write = 1'b0;
    endtask

    task automatic wait_empty(input string name, input bit chk_lat);
        int n;
        int d;
        n = 0;
        while (bus.buf_empty !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.buf_empty !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_empty_timeout: got buf_empty=%b expected 1", name, bus.buf_empty);
        end else if (chk_lat) begin
            d = cyc - last_presp_cyc;
            chk_bit({name, "_empty_after_resp"}, (d >= 1 && d <= 2), 1'b1);
        end
        chk_int({name, "_pmem_queue_drained"}, pq.size(), 0);
    endtask

    task automatic check_idle(input string name);
        chk_bit({name, "_cache_resp"}, bus.cache_resp, 1'b0);
        chk({name, "_cache_rdata"}, bus.cache_rdata, '0);
        chk_bit({name, "_pmem_read"}, bus.pmem_read, 1'b0);
        chk_bit({name, "_pmem_write"}, bus.pmem_write, 1'b0);
        chk({name, "_pmem_address"}, 256'(bus.pmem_address), '0);
        chk({name, "_pmem_wdata"}, bus.pmem_wdata, '0);
        chk_bit({name, "_buf_empty"}, bus.buf_empty, 1'b1);
    endtask

    int resp_before;
    initial begin
        rst               = 1'b0;
        bus.cache_address = '0;
        bus.cache_wdata   = '0;
        bus.cache_read    = 1'b0;
        bus.cache_write   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("por");
        rst = 1'b1;

        // Reset while a drain is held in flight; nothing may reissue afterwards.
        mem_hold = 1'b1;
        push_pm(1'b1, 32'h0000_5000, pat(32'h0000_5000));
        cache_op(1'b0, 32'h0000_5000, pat(32'h0000_5000), '0, 1, "wr5000");
        repeat (4) @(posedge clk);
        #2;
        chk_bit("inflight_pmem_write", bus.pmem_write, 1'b1);
        mem_flush = 1'b1;
        rst = 1'b0;
        #1;
        check_idle("midreset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk_bit("post_reset_no_write", bus.pmem_write, 1'b0);
        chk_bit("post_reset_buf_empty", bus.buf_empty, 1'b1);
        mem_flush = 1'b0;
        mem_hold  = 1'b0;

        // Single write and its drain.
        push_pm(1'b1, 32'h0000_1020, pat(32'hD1D1_0001));
        cache_op(1'b0, 32'h0000_1020, pat(32'hD1D1_0001), '0, 1, "wr1020");
        chk_bit("buf_not_empty_after_write", bus.buf_empty, 1'b0);
        wait_empty("drain1020", 1'b1);

        // Fill to DEPTH with the first drain withheld; the fifth write must stall.
        mem_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push_pm(1'b1, 32'(i * 32'h100), pat(32'(i * 32'h100)));
            cache_op(1'b0, 32'(i * 32'h100), pat(32'(i * 32'h100)), '0, 1, "fill");
        end
        push_pm(1'b1, 32'h0000_0500, pat(32'h0000_0500));
        resp_before = last_resp_cyc;
        fork
            cache_op(1'b0, 32'h0000_0500, pat(32'h0000_0500), '0, -1, "wr500_full");
            begin
                repeat (6) @(posedge clk);
                #1;
                chk_bit("full_no_resp", (last_resp_cyc == resp_before), 1'b1);
                mem_grant = 1;
            end
        join
        chk_bit("full_release_latency", ((last_resp_cyc - last_presp_cyc) >= 1 &&
                                         (last_resp_cyc - last_presp_cyc) <= 2), 1'b1);
        mem_hold = 1'b0;
        wait_empty("fill_drain", 1'b0);

        // Coalescing behind a held drain, then a read hit of the merged line.
        mem_hold = 1'b1;
        push_pm(1'b1, 32'h0000_1000, pat(32'h0000_1000));
        cache_op(1'b0, 32'h0000_1000, pat(32'h0000_1000), '0, 1, "wr1000");
        push_pm(1'b1, 32'h0000_2000, pat(32'hD2D2_0002));
        cache_op(1'b0, 32'h0000_2000, pat(32'hD1D1_0001), '0, 1, "wr2000_d1");
        cache_op(1'b0, 32'h0000_201F, pat(32'hD2D2_0002), '0, 1, "wr2000_d2");
        cache_op(1'b1, 32'h0000_2000, '0, pat(32'hD2D2_0002), 1, "rd2000_hit");
        mem_hold = 1'b0;
        wait_empty("coalesce_drain", 1'b0);

        // Hit on the in-flight head, then a miss that must wait for the drain.
        mem_hold = 1'b1;
        push_pm(1'b1, 32'h0000_3000, pat(32'h0000_3000));
        cache_op(1'b0, 32'h0000_3000, pat(32'h0000_3000), '0, 1, "wr3000");
        repeat (3) @(posedge clk);
        cache_op(1'b1, 32'h0000_3000, '0, pat(32'h0000_3000), 1, "rd3000_head_hit");
        push_pm(1'b0, 32'h0000_4000, '0);
        fork
            cache_op(1'b1, 32'h0000_4013, '0, memdat(32'h0000_4000), -1, "rd4000_miss");
            begin
                repeat (5) @(posedge clk);
                #1;
                mem_hold = 1'b0;
            end
        join
        chk_int("miss_resp_after_pmem_resp", last_resp_cyc - last_presp_cyc, 1);
        wait_empty("miss_drain", 1'b0);
        chk_int("cache_queue_drained", cq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/p_d_cache_wb_buffer.md
Name: p_d_cache_wb_buffer

Overview:
- Write-back buffer between the pipelined D-cache's physical-memory port and the memory arbiter / cacheline adaptor.
- Absorbs dirty-line evictions so the cache can refill immediately.
- Serves reads that hit a buffered line directly from the buffer.
- Drains buffered lines to memory in FIFO order when the downstream port is idle.

Parameters:
- DEPTH, 4, number of 256-bit line entries (power of two, ≥2).
- s_offset, 5, line offset bits; the address compare ignores bits [s_offset-1:0].

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cache_address  in  32  line address from D-cache (pmem_address side).
- cache_wdata  in  256  eviction line data.
- cache_read  in  1  line read request; held until cache_resp.
- cache_write  in  1  line write request; held until cache_resp.
- cache_resp  out  1  one-cycle completion pulse to D-cache.
- cache_rdata  out  256  read line data; valid when cache_resp is high for a read.
- pmem_address  out  32  downstream line address; low s_offset bits are driven 0.
- pmem_wdata  out  256  downstream write data.
- pmem_read  out  1  downstream read request; held until pmem_resp.
- pmem_write  out  1  downstream write request; held until pmem_resp.
- pmem_resp  in  1  downstream completion pulse.
- pmem_rdata  in  256  downstream read data; valid with pmem_resp.
- buf_empty  out  1  high when no valid entries and FSM is IDLE (used for fence/drain).

Behaviour:
- Reset (rst low, async): all entries invalid, head = tail = count = 0, FSM IDLE. Outputs: cache_resp = 0, cache_rdata = 0, pmem_read = 0, pmem_write = 0, pmem_address = 0, pmem_wdata = 0, buf_empty = 1.
- Reset mid-transaction abandons any in-flight downstream request without completing it.
- Storage: circular FIFO of {tag = address[31:s_offset], data}, with head/tail pointers that wrap modulo DEPTH and count in 0..DEPTH.
- Accept rule: an upstream request is evaluated only in cycles where cache_resp is 0. This prevents double-accepting a request still held during its resp cycle.
- Write accept: cache_write = 1 and count < DEPTH (sampled this cycle).
  - Entry written at tail; tail++ and count++ at the edge.
  - cache_resp pulses the next cycle (1-cycle latency).
  - If full, no resp; the request stays pending until a drain completes.
- Write coalescing: if a valid entry has a matching tag and is not the head currently being drained, overwrite its data in place. Count is unchanged; resp next cycle.
- Read hit: cache_read = 1 and a tag matches a valid entry. Return the newest matching entry (closest to tail); cache_rdata registered, cache_resp the next cycle. No downstream traffic.
- Read miss: cache_read = 1, no match, FSM IDLE → READ_MEM at the next edge.
  - pmem_read = 1 with the line address.
  - On pmem_resp: latch pmem_rdata into cache_rdata, pulse cache_resp the next cycle, return to IDLE.
  - Misses bypass queued writes. This is safe because the address did not match any entry.
- FSM states:
  - IDLE: a pending read miss has priority → READ_MEM. Else if count > 0 → WRITE_MEM (head entry).
  - READ_MEM: pmem_read held; on pmem_resp → IDLE.
  - WRITE_MEM: pmem_write held with head address/data; on pmem_resp, head++ and count-- at the edge → IDLE.
- A drain in progress is never preempted. A read miss arriving during WRITE_MEM waits for the drain to finish, then IDLE picks the read.
- Head in flight remains valid until pmem_resp, so reads to it hit in the buffer.
- Simultaneous enqueue and dequeue at the same edge: the count update is +1−1 = 0. Full is evaluated on the pre-edge count, so a full buffer never accepts in the drain-completion cycle.
- cache_read and cache_write both high: illegal; the bench asserts this never occurs.
- buf_empty = (count == 0) && IDLE && !cache_resp pending.

Test Plan:
- Reset with rst low mid-WRITE_MEM → all outputs 0, buf_empty = 1; after release, no pmem_write is issued.
- Write A = 0x0000_1020, data D1 → cache_resp at cycle +1, count = 1. Then pmem_write with address 0x0000_1020 and D1. After pmem_resp (3-cycle mem latency), buf_empty = 1 two cycles later.
- Fill 4 writes (addresses 0x100, 0x200, 0x300, 0x400) with pmem_resp withheld → the fifth write to 0x500 gets no cache_resp. Release one pmem_resp → the 0x500 write resps within 2 cycles, and drain order is 0x100, 0x200, 0x300, 0x400, 0x500.
- Write 0x2000 = D1, then 0x2000 = D2 (coalesce), then read 0x2000 → cache_resp one cycle after the read with cache_rdata = D2, and no pmem_read.
- With 0x3000 queued and pmem_write in flight, issue read 0x4000 → pmem_read for 0x4000 only after the write's pmem_resp. cache_rdata equals the mem data, and cache_resp is 1 cycle after pmem_resp.
- Read 0x3000 while 0x3000 is the in-flight head → hit returns the buffered data at cycle +1, with no pmem_read.
